sram_port_ctrl: RTL and testbench

SRAM_PORT_CTRL -- requirements
Module: sram_port_ctrl

---
 rtl/sram_ctrl_pkg.sv | 11 +
 rtl/sram_port_ctrl.sv | 103 ++++++++++
 tb/tb_sram_port_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared widths and FSM encoding for the SRAM port controller
package sram_ctrl_pkg;
    localparam int ADDR_W_DFLT = 10;
    localparam int DEPTH_DFLT  = 256;
    localparam int BYTE_W      = 8;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;
endpackage

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: byte-serial SRAM write port, single-cycle reads and a sweep-to-zero clear
module sram_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DEPTH  = DEPTH_DFLT
) (
    input  logic              clk,
    input  logic              srstn,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_data_valid,
    output logic [31:0]       rd_data,
    input  logic              clr_start,
    output logic              busy,
    output logic              sram_csb,
    output logic              sram_wsb,
    output logic [3:0]        sram_bytemask,
    output logic [7:0]        sram_wdata,
    output logic [ADDR_W-1:0] sram_waddr,
    output logic [ADDR_W-1:0] sram_raddr,
    input  logic [31:0]       sram_rdata
);
    state_t            state, state_n;
    logic [1:0]        byte_cnt, byte_cnt_n;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_n, addr_q, addr_n;
    logic [31:0]       data_q, data_n;
    logic              wr_fire, rd_fire;

    assign busy     = state != IDLE;
    assign wr_ready = srstn && ((state == IDLE && !clr_start) || (state == WRITE && byte_cnt == 2'd3));
    assign rd_ready = srstn && state != CLEAR && !(state == WRITE && rd_addr == addr_q);
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_fire  = rd_valid && rd_ready;
    assign rd_data  = sram_rdata;

    // The SRAM is busy whenever the FSM writes or a read is accepted; write lanes come from the byte counter
    assign sram_csb      = state == IDLE && !rd_fire;
    assign sram_wsb      = state == IDLE;
    assign sram_bytemask = state == WRITE ? 4'(4'b0001 << byte_cnt) : 4'b0000;
    assign sram_wdata    = state == WRITE ? data_q[byte_cnt*BYTE_W +: BYTE_W] : '0;
    assign sram_waddr    = state == WRITE ? addr_q : state == CLEAR ? clr_cnt : '0;
    assign sram_raddr    = rd_fire ? rd_addr : '0;

    // State and datapath registers, cleared by the synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!srstn) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            clr_cnt       <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            rd_data_valid <= 1'b0;
        end else begin
            state         <= state_n;
            byte_cnt      <= byte_cnt_n;
            clr_cnt       <= clr_cnt_n;
            addr_q        <= addr_n;
            data_q        <= data_n;
            rd_data_valid <= rd_fire;
        end
    end

    // Next state: clear beats a write in IDLE; a write accepted on byte 3 restarts WRITE with no gap
    always_comb begin
        state_n    = state;
        byte_cnt_n = byte_cnt;
        clr_cnt_n  = clr_cnt;
        addr_n     = addr_q;
        data_n     = data_q;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_n   = CLEAR;
                    clr_cnt_n = '0;
                end
            end
            WRITE: begin
                byte_cnt_n = byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) state_n = IDLE;
            end
            CLEAR: begin
                clr_cnt_n = clr_cnt + 1'b1;
                if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                    state_n   = IDLE;
                    clr_cnt_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
        if (wr_fire) begin
            state_n    = WRITE;
            byte_cnt_n = '0;
            addr_n     = wr_addr;
            data_n     = wr_data;
        end
    end
endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb_sram_port_ctrl: directed and random checks of sram_port_ctrl against a word-level memory model
module tb_sram_port_ctrl;
    localparam int AW = 10;
    localparam int NW = 1 << AW;

    logic          clk = 1'b0, srstn = 1'b0;
    logic          wr_valid = 1'b0, rd_valid = 1'b0, clr_start = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [31:0]   wr_data = '0;
    logic          wr_ready, rd_ready, rd_data_valid, busy;
    logic [31:0]   rd_data;
    logic          sram_csb, sram_wsb;
    logic [3:0]    sram_bytemask;
    logic [7:0]    sram_wdata;
    logic [AW-1:0] sram_waddr, sram_raddr;
    logic [31:0]   rdata_q = '0;
    logic [31:0]   mem [NW] = '{default: '0};
    logic [31:0]   ref_mem [NW];
    int            tests = 0, fails = 0;

    sram_port_ctrl #(.ADDR_W(AW), .DEPTH(256)) dut (
        .clk(clk), .srstn(srstn),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .clr_start(clr_start), .busy(busy),
        .sram_csb(sram_csb), .sram_wsb(sram_wsb), .sram_bytemask(sram_bytemask),
        .sram_wdata(sram_wdata), .sram_waddr(sram_waddr), .sram_raddr(sram_raddr),
        .sram_rdata(rdata_q)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] m, input logic [7:0] b);
        logic [31:0] w;
        w = old;
        for (int i = 0; i < 4; i++) if (m[i]) w[8*i +: 8] = b;
        return w;
    endfunction

    // Behavioural SRAM: registered read of the old word, byte-lane write, empty mask zeroes the word
    always @(posedge clk) begin
        if (!sram_csb) begin
            rdata_q <= mem[sram_raddr];
            if (!sram_wsb) mem[sram_waddr] <= sram_bytemask == 4'b0 ? 32'h0 : merge(mem[sram_waddr], sram_bytemask, sram_wdata);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_byte(input logic [AW-1:0] a, input logic [31:0] d, input int k);
        chk("w.csb", sram_csb, 0);
        chk("w.wsb", sram_wsb, 0);
        chk("w.mask", sram_bytemask, 32'(1) << k);
        chk("w.wdata", sram_wdata, (d >> (8 * k)) & 32'hff);
        chk("w.waddr", sram_waddr, a);
    endtask

    task automatic wait_ready(input string tag, input bit wr);
        int n = 0;
        while (!(wr ? wr_ready : rd_ready) && n < 300) begin
            tick();
            #1;
            n++;
        end
        chk(tag, wr ? wr_ready : rd_ready, 1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        #1;
        wait_ready("wr_ready", 1'b1);
        tick();
        wr_valid = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk_byte(a, d, k);
            tick();
            #1;
        end
        ref_mem[a] = d;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        rd_valid = 1'b1; rd_addr = a;
        #1;
        wait_ready("rd_ready", 1'b0);
        chk("r.csb", sram_csb, 0);
        chk("r.raddr", sram_raddr, a);
        tick();
        rd_valid = 1'b0;
        #1;
        chk("r.valid", rd_data_valid, 1);
        chk("r.data", rd_data, ref_mem[a]);
    endtask

    task automatic do_collide(input logic [AW-1:0] a, input logic [31:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        rd_valid = 1'b1; rd_addr = a;
        #1;
        chk("col.wr_ready", wr_ready, 1);
        chk("col.rd_ready", rd_ready, 1);
        chk("col.csb", sram_csb, 0);
        chk("col.wsb", sram_wsb, 1);
        chk("col.raddr", sram_raddr, a);
        tick();
        wr_valid = 1'b0; rd_valid = 1'b0;
        #1;
        chk("col.valid", rd_data_valid, 1);
        chk("col.data", rd_data, ref_mem[a]);
        for (int k = 0; k < 4; k++) begin
            chk_byte(a, d, k);
            tick();
            #1;
        end
        ref_mem[a] = d;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".rvalid"}, rd_data_valid, 0);
        chk({tag, ".csb"}, sram_csb, 1);
        chk({tag, ".wsb"}, sram_wsb, 1);
        chk({tag, ".mask"}, sram_bytemask, 0);
        chk({tag, ".wdata"}, sram_wdata, 0);
        chk({tag, ".waddr"}, sram_waddr, 0);
        chk({tag, ".raddr"}, sram_raddr, 0);
        chk({tag, ".wr_ready"}, wr_ready, 0);
        chk({tag, ".rd_ready"}, rd_ready, 0);
    endtask

    initial begin
        for (int i = 0; i < NW; i++) ref_mem[i] = '0;
        tick();
        tick();
        #1;
        chk_reset_outputs("rst");
        srstn = 1'b1;
        tick();
        #1;
        chk("idle.wr_ready", wr_ready, 1);
        chk("idle.rd_ready", rd_ready, 1);

        do_write(5, 32'h11223344);
        do_read(5);
        tick();
        #1;
        chk("r.valid_drop", rd_data_valid, 0);

        wr_valid = 1'b1; wr_addr = 1; wr_data = 32'hAABBCCDD;
        #1;
        chk("b2b.rdy_first", wr_ready, 1);
        tick();
        wr_addr = 2; wr_data = 32'h01020304;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk_byte(1, 32'hAABBCCDD, k);
            chk("b2b.rdy", wr_ready, k == 3);
            tick();
            if (k == 3) wr_valid = 1'b0;
            #1;
        end
        for (int k = 0; k < 4; k++) begin
            chk_byte(2, 32'h01020304, k);
            tick();
            #1;
        end
        ref_mem[1] = 32'hAABBCCDD;
        ref_mem[2] = 32'h01020304;
        do_read(1);
        do_read(2);

        do_write(9, 32'h12345678);
        do_write(8, 32'hCAFEF00D);
        wr_valid = 1'b1; wr_addr = 7; wr_data = 32'h0BADBEEF;
        #1;
        tick();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 7;
        #1;
        chk_byte(7, 32'h0BADBEEF, 0);
        chk("haz.rdy7_b0", rd_ready, 0);
        tick();
        #1;
        chk_byte(7, 32'h0BADBEEF, 1);
        chk("haz.rdy7_b1", rd_ready, 0);
        tick();
        rd_addr = 8;
        #1;
        chk_byte(7, 32'h0BADBEEF, 2);
        chk("haz.rdy8", rd_ready, 1);
        chk("haz.raddr8", sram_raddr, 8);
        tick();
        rd_valid = 1'b0; rd_addr = 7;
        #1;
        chk_byte(7, 32'h0BADBEEF, 3);
        chk("haz.rdy7_b3", rd_ready, 0);
        chk("haz.valid8", rd_data_valid, 1);
        chk("haz.data8", rd_data, 32'hCAFEF00D);
        tick();
        #1;
        ref_mem[7] = 32'h0BADBEEF;
        chk("haz.rdy7_idle", rd_ready, 1);
        do_read(7);

        do_collide(9, 32'h0);
        do_read(9);

        do_write(300, 32'h55AA55AA);
        clr_start = 1'b1; wr_valid = 1'b1; wr_addr = 600; wr_data = 32'hFFFFFFFF;
        rd_valid = 1'b1; rd_addr = 300;
        #1;
        chk("clr.wr_ready_start", wr_ready, 0);
        tick();
        clr_start = 1'b0;
        #1;
        for (int i = 0; i < 256; i++) begin
            chk("clr.busy", busy, 1);
            chk("clr.csb", sram_csb, 0);
            chk("clr.wsb", sram_wsb, 0);
            chk("clr.mask", sram_bytemask, 0);
            chk("clr.waddr", sram_waddr, i);
            chk("clr.wr_ready", wr_ready, 0);
            chk("clr.rd_ready", rd_ready, 0);
            if (i == 255) begin
                wr_valid = 1'b0;
                rd_valid = 1'b0;
            end
            tick();
            #1;
        end
        chk("clr.busy_end", busy, 0);
        chk("clr.csb_end", sram_csb, 1);
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        do_read(0);
        do_read(5);
        do_read(255);
        do_read(300);
        do_read(600);

        wr_valid = 1'b1; wr_addr = 3; wr_data = 32'hFFFFFFFF;
        #1;
        tick();
        wr_valid = 1'b0;
        #1;
        chk_byte(3, 32'hFFFFFFFF, 0);
        tick();
        srstn = 1'b0; rd_addr = 50;
        #1;
        chk_byte(3, 32'hFFFFFFFF, 1);
        chk("mrst.rd_ready", rd_ready, 0);
        chk("mrst.wr_ready", wr_ready, 0);
        tick();
        #1;
        chk_reset_outputs("mrst");
        srstn = 1'b1;
        tick();
        #1;
        chk("mrst.busy_after", busy, 0);
        chk("mrst.csb_after", sram_csb, 1);
        ref_mem[3] = 32'h0000FFFF;
        do_read(3);

        for (int n = 0; n < 60; n++) begin
            logic [AW-1:0] a;
            int            op;
            a  = AW'($urandom_range(0, 15));
            op = int'($urandom_range(0, 2));
            if (op == 0) do_read(a);
            else if (op == 1) do_write(a, $urandom);
            else do_collide(a, $urandom);
        end
        for (int a = 0; a < 16; a++) do_read(AW'(a));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
